// File: rtl/decode_rename_pipe_buffer.sv
// decode_rename_pipe_buffer
// Decode-to-rename boundary buffer. It holds a DEPTH-entry FIFO of
// LANES-wide micro-op groups and a redirect register toward fetch. A
// backend flush empties the FIFO and drops any pending redirect.
module decode_rename_pipe_buffer #(
    parameter int LANES     = 2,
    parameter int PAYLOAD_W = 64,
    parameter int PC_W      = 32,
    parameter int HIST_W    = 10,
    parameter int RAS_W     = 16,
    parameter int DEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    // decode side
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES-1:0]              in_lane_valid,
    input  logic [LANES*PAYLOAD_W-1:0]    in_payload,
    // rename side
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0]              out_lane_valid,
    output logic [LANES*PAYLOAD_W-1:0]    out_payload,
    // recovery
    input  logic                          dec_flush,
    input  logic [PC_W-1:0]               dec_pc,
    input  logic [HIST_W-1:0]             dec_hist,
    input  logic [RAS_W-1:0]              dec_ras,
    input  logic                          be_flush,
    output logic                          redir_valid,
    input  logic                          redir_ready,
    output logic [PC_W-1:0]               redir_pc,
    output logic [HIST_W-1:0]             redir_hist,
    output logic [RAS_W-1:0]              redir_ras,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [LANES-1:0]           laneValidMem [DEPTH];
    logic [LANES*PAYLOAD_W-1:0] payloadMem   [DEPTH];

    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] groupCount;
    logic             doPush;
    logic             doPop;

    // Advance a pointer and wrap it back to zero after the last entry.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // in_ready depends only on the occupancy, so it has no path from
    // out_ready. A group whose lane-valids are all zero still completes
    // the handshake but does not take an entry.
    assign in_ready  = (groupCount < CNT_W'(DEPTH));
    assign out_valid = (groupCount != '0);
    assign doPush    = in_valid && in_ready && !be_flush && (|in_lane_valid);
    assign doPop     = out_valid && out_ready && !be_flush;
    assign count     = groupCount;

    // The head entry drives the outputs. They read zero while the buffer is
    // empty, so stale storage contents never appear on the outputs.
    assign out_lane_valid = out_valid ? laneValidMem[headPtr] : '0;
    assign out_payload    = out_valid ? payloadMem[headPtr]   : '0;

    // Update the pointers and the occupancy. A backend flush overrides everything else.
    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the pre-edge values, whatever order the blocks evaluate in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            headPtr    <= '0;
            tailPtr    <= '0;
            groupCount <= '0;
        end else if (be_flush) begin
            headPtr    <= '0;
            tailPtr    <= '0;
            groupCount <= '0;
        end else begin
            if (doPush) tailPtr <= nextPtr(tailPtr);
            if (doPop)  headPtr <= nextPtr(headPtr);
            case ({doPush, doPop})
                2'b10:   groupCount <= groupCount + 1'b1;
                2'b01:   groupCount <= groupCount - 1'b1;
                default: groupCount <= groupCount;
            endcase
        end
    end

    // Write an accepted group into the tail entry, keeping lane order and lane-valids as they arrive.
    // NOTE: the storage array is not reset. The entries are only observed
    // while the count marks them valid, and the outputs are gated to zero otherwise.
    always_ff @(posedge clk) begin
        if (doPush) begin
            laneValidMem[tailPtr] <= in_lane_valid;
            payloadMem[tailPtr]   <= in_payload;
        end
    end

    // Redirect register. The latest dec_flush wins, a new load takes
    // priority over a same-cycle handshake, and be_flush drops the pending redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            redir_hist  <= '0;
            redir_ras   <= '0;
        end else if (be_flush) begin
            redir_valid <= 1'b0;
        end else if (dec_flush) begin
            redir_valid <= 1'b1;
            redir_pc    <= dec_pc;
            redir_hist  <= dec_hist;
            redir_ras   <= dec_ras;
        end else if (redir_ready) begin
            redir_valid <= 1'b0;
        end
    end

endmodule

// File: doc/decode_rename_pipe_buffer.md
# decode_rename_pipe_buffer

Parametrised decode→rename boundary buffer: a DEPTH-entry group FIFO carrying up to LANES decoded micro-op slots per group, plus a held recovery-redirect register (PC, branch global history, RAS checkpoint) toward fetch. It replaces a single-entry decode/rename register with valid/ready backpressure, configurable lane count and depth, a pending-redirect handshake, and a backend-flush kill path. It sits between the decode stage and the rename stage.

## Interface
Parameters:
- LANES, 2, micro-op slots per group (decode width)
- PAYLOAD_W, 64, bits per lane payload (rename-stage register path)
- PC_W, 32, recovered PC width
- HIST_W, 10, branch global history width
- RAS_W, 16, RAS checkpoint width
- DEPTH, 2, group entries (≥1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock, rising edge
  - rst  in  1  reset
- in_valid  in  1  decode presents a group
- in_ready  out  1  buffer can accept a group
- in_lane_valid  in  LANES  per-lane valid
- in_payload  in  LANES*PAYLOAD_W  lane i at [i*PAYLOAD_W +: PAYLOAD_W]
- out_valid  out  1  head group valid
- out_ready  in  1  rename consumes head
- out_lane_valid  out  LANES  head per-lane valid
- out_payload  out  LANES*PAYLOAD_W  head payload
- dec_flush  in  1  decode-detected misprediction; capture redirect
- dec_pc / dec_hist / dec_ras  in  PC_W / HIST_W / RAS_W  recovery data
- be_flush  in  1  backend flush; kills everything held
- redir_valid  out  1  redirect pending toward fetch
- redir_ready  in  1  fetch accepts redirect
- redir_pc / redir_hist / redir_ras  out  PC_W / HIST_W / RAS_W  held recovery data
- count  out  $clog2(DEPTH+1)  groups held

## Operation
- FIFO of DEPTH groups; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
- in_ready = (count < DEPTH); no combinational path from out_ready to in_ready.
- Push when in_valid && in_ready && !be_flush && |in_lane_valid. Accepted group with all lane-valids 0 is consumed and discarded (no entry).
- out_valid = (count != 0); out_* driven from head storage; pop when out_valid && out_ready && !be_flush.
- Simultaneous push and pop at count==DEPTH impossible (in_ready=0); at other counts count is unchanged.
- Lane order and per-lane valid bits are preserved exactly; no compaction.
- Redirect register:
  - dec_flush && !be_flush loads dec_* into redir_*, sets redir_valid.
  - redir_valid clears on redir_ready unless dec_flush loads a new value in the same cycle (new value wins, valid stays 1).
  - dec_flush while pending overwrites (latest wins).
  - dec_flush does not touch FIFO contents; same-cycle push proceeds.
- be_flush: next cycle count=0, pointers=0, redir_valid=0; same-cycle push, pop and dec_flush ignored.

## Timing
- Reset (rst low, async): count=0, pointers=0, out_valid=0, out_lane_valid=0, out_payload=0, redir_valid=0, redir_pc/hist/ras=0, in_ready=1.
- Reset deassertion mid-traffic: first edge after release behaves as from empty.
- Latency in→out: 1 cycle (group pushed at edge t is visible with out_valid at t+1 if FIFO was empty).
- Throughput: 1 group/cycle sustained for DEPTH≥2 with out_ready held 1; DEPTH=1 gives 1 group per 2 cycles only if in_ready is sampled before pop (by design it is).
- redir_valid rises the cycle after dec_flush; held stable (all redir_* fields) until handshake.
- be_flush effect visible the cycle after assertion.

## Test plan
- Reset, then push groups A(lanes 11), B(01), C(10) with out_ready=0, DEPTH=2 -> A,B stored, count=2, in_ready=0, C stalled; raise out_ready -> A,B,C emerge in order with exact lane-valids.
- Continuous push/pop 20 groups, out_ready=1 -> out_valid one cycle after each push, count never exceeds 1, no drops, pointers wrap.
- Push group with in_lane_valid=00 -> in_ready handshake completes, count stays 0, out_valid stays 0.
- dec_flush pc=0x100 with redir_ready=0, then dec_flush pc=0x200 -> redir_pc=0x200, redir_valid held; redir_ready=1 with dec_flush pc=0x300 same cycle -> redir_valid stays 1, redir_pc=0x300; next cycle redir_ready alone -> redir_valid=0.
- count=2, redir pending, be_flush with simultaneous in_valid, dec_flush, out_ready -> next cycle count=0, out_valid=0, redir_valid=0, nothing pushed.
- Assert rst mid-stream with count=2 and redir pending -> all outputs at reset values immediately (asynchronously), before next clk edge.
